// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB bus among four requesters and runs the
// SETUP/ACCESS handshake itself, with a PREADY timeout guarding every ACCESS phase.
module apb_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_write,
   input  logic [7*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic [7:0]        rdata,
   output logic [NREQ-1:0]   grant,
   output logic              PSELECT1,
   output logic              PSELECT2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [6:0]        PADDR,
   output logic [7:0]        PWDATA,
   input  logic [7:0]        PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t          state;
   logic [1:0]      rr_ptr;
   logic [7:0]      tmo_cnt;

   logic [NREQ-1:0] req_eff;
   logic            any_req;
   logic            found;
   logic [1:0]      cand;
   logic [1:0]      win_idx;
   logic [NREQ-1:0] win_oh;
   logic [6:0]      win_addr;
   logic [7:0]      win_wdata;
   logic            win_write;

   // A requester just completed still holds req in its done cycle; mask it out.
   always_comb begin
      req_eff   = req & ~done;
      any_req   = |req_eff;
      found     = 1'b0;
      cand      = 2'd0;
      win_idx   = rr_ptr;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_ptr + 2'(k);
         if (!found && req_eff[cand]) begin
            win_idx = cand;
            found   = 1'b1;
         end
      end
      win_oh    = '0;
      win_oh[win_idx] = 1'b1;
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == 2'(i)) begin
            win_addr  = req_addr[7*i +: 7];
            win_wdata = req_wdata[8*i +: 8];
            win_write = req_write[i];
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state    <= S_IDLE;
         rr_ptr   <= 2'd3;
         tmo_cnt  <= '0;
         done     <= '0;
         err      <= '0;
         grant    <= '0;
         rdata    <= '0;
         PSELECT1 <= 1'b0;
         PSELECT2 <= 1'b0;
         PENABLE  <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= '0;
         PWDATA   <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant    <= win_oh;
                  PADDR    <= win_addr;
                  PWRITE   <= win_write;
                  PWDATA   <= win_wdata;
                  PSELECT1 <= win_addr[6];
                  PSELECT2 <= ~win_addr[6];
                  rr_ptr   <= win_idx;
                  state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               PENABLE <= 1'b1;
               tmo_cnt <= '0;
               state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  if (!PWRITE) rdata <= PRDATA;
                  done     <= grant;
                  err      <= PSLVERR ? grant : '0;
                  grant    <= '0;
                  PSELECT1 <= 1'b0;
                  PSELECT2 <= 1'b0;
                  PENABLE  <= 1'b0;
                  state    <= S_IDLE;
               end else if (tmo_cnt == 8'(TIMEOUT-1)) begin
                  // Hung slave: force completion with an error and a clean rdata.
                  rdata    <= '0;
                  done     <= grant;
                  err      <= grant;
                  grant    <= '0;
                  PSELECT1 <= 1'b0;
                  PSELECT2 <= 1'b0;
                  PENABLE  <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for timeout, round-robin and reset mid-transfer.
module tb_apb_req_arbiter;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [3:0]  req, req_write;
   logic [27:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  done, err, grant;
   logic [7:0]  rdata;
   logic        PSELECT1, PSELECT2, PENABLE, PWRITE;
   logic [6:0]  PADDR;
   logic [7:0]  PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int n_checks = 0;
   int n_errors = 0;

   apb_req_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
      .rdata(rdata), .grant(grant), .PSELECT1(PSELECT1), .PSELECT2(PSELECT2),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic       rst;
      logic [3:0] rq;
      logic [3:0] wr;
      logic       rdy;
      logic       slv;
      logic [7:0] prd;
      logic [3:0] g;
      logic       s1;
      logic       s2;
      logic       en;
      logic [3:0] dn;
      logic [3:0] er;
      logic [7:0] rd;
      logic [6:0] pa;
      logic [7:0] pw;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mkv(logic rst, logic [3:0] rq, logic [3:0] wr, logic rdy,
                                logic slv, logic [7:0] prd, logic [3:0] g, logic s1,
                                logic s2, logic en, logic [3:0] dn, logic [3:0] er,
                                logic [7:0] rd, logic [6:0] pa, logic [7:0] pw);
      vec_t v;
      v.rst = rst; v.rq = rq; v.wr = wr; v.rdy = rdy; v.slv = slv; v.prd = prd;
      v.g = g; v.s1 = s1; v.s2 = s2; v.en = en; v.dn = dn; v.er = er;
      v.rd = rd; v.pa = pa; v.pw = pw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk_bus(input string tag, input logic [3:0] g, input logic s1,
                          input logic s2, input logic en, input logic [3:0] dn,
                          input logic [3:0] er);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".psel1"}, 32'(PSELECT1), 32'(s1));
      chk({tag, ".psel2"}, 32'(PSELECT2), 32'(s2));
      chk({tag, ".penable"}, 32'(PENABLE), 32'(en));
      chk({tag, ".done"}, 32'(done), 32'(dn));
      chk({tag, ".err"}, 32'(err), 32'(er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rr_exp [5];
      logic [6:0] rr_addr [5];

      // requester 3: 0x50 (slave 1), 2: 0x12 (slave 2), 1: 0x20 (slave 2), 0: 0x45 (slave 1)
      req_addr  = {7'h50, 7'h12, 7'h20, 7'h45};
      req_wdata = {8'h77, 8'h5A, 8'h11, 8'hA5};
      PRESET = 1'b1; req = '0; req_write = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

      //              rst rq    wr    rdy slv prd    | g     s1 s2 en dn    er    rd     pa     pw
      vecs[0]  = mkv(1, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 7'h00, 8'h00);
      vecs[1]  = mkv(0, 4'h1, 4'h1, 0, 0, 8'h00, 4'h1, 1, 0, 0, 4'h0, 4'h0, 8'h00, 7'h45, 8'hA5);
      vecs[2]  = mkv(0, 4'h1, 4'h1, 1, 0, 8'h00, 4'h1, 1, 0, 1, 4'h0, 4'h0, 8'h00, 7'h45, 8'hA5);
      vecs[3]  = mkv(0, 4'h1, 4'h1, 1, 0, 8'h00, 4'h0, 0, 0, 0, 4'h1, 4'h0, 8'h00, 7'h45, 8'hA5);
      vecs[4]  = mkv(0, 4'h1, 4'h1, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 7'h45, 8'hA5);
      vecs[5]  = mkv(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 7'h45, 8'hA5);
      vecs[6]  = mkv(0, 4'h4, 4'h0, 0, 0, 8'h00, 4'h4, 0, 1, 0, 4'h0, 4'h0, 8'h00, 7'h12, 8'h5A);
      vecs[7]  = mkv(0, 4'h4, 4'h0, 0, 0, 8'h00, 4'h4, 0, 1, 1, 4'h0, 4'h0, 8'h00, 7'h12, 8'h5A);
      vecs[8]  = mkv(0, 4'h4, 4'h0, 0, 0, 8'h00, 4'h4, 0, 1, 1, 4'h0, 4'h0, 8'h00, 7'h12, 8'h5A);
      vecs[9]  = mkv(0, 4'h4, 4'h0, 0, 1, 8'h00, 4'h4, 0, 1, 1, 4'h0, 4'h0, 8'h00, 7'h12, 8'h5A);
      vecs[10] = mkv(0, 4'h4, 4'h0, 0, 0, 8'hEE, 4'h4, 0, 1, 1, 4'h0, 4'h0, 8'h00, 7'h12, 8'h5A);
      vecs[11] = mkv(0, 4'h4, 4'h0, 1, 0, 8'h3C, 4'h0, 0, 0, 0, 4'h4, 4'h0, 8'h3C, 7'h12, 8'h5A);
      vecs[12] = mkv(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 4'h0, 8'h3C, 7'h12, 8'h5A);
      vecs[13] = mkv(0, 4'h8, 4'h8, 0, 0, 8'h00, 4'h8, 1, 0, 0, 4'h0, 4'h0, 8'h3C, 7'h50, 8'h77);
      vecs[14] = mkv(0, 4'h8, 4'h8, 1, 1, 8'h00, 4'h8, 1, 0, 1, 4'h0, 4'h0, 8'h3C, 7'h50, 8'h77);
      vecs[15] = mkv(0, 4'h8, 4'h8, 1, 1, 8'h99, 4'h0, 0, 0, 0, 4'h8, 4'h8, 8'h3C, 7'h50, 8'h77);
      vecs[16] = mkv(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 4'h0, 8'h3C, 7'h50, 8'h77);

      for (int i = 0; i < 17; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         PRESET = vecs[i].rst; req = vecs[i].rq; req_write = vecs[i].wr;
         PREADY = vecs[i].rdy; PSLVERR = vecs[i].slv; PRDATA = vecs[i].prd;
         tick();
         chk_bus(tag, vecs[i].g, vecs[i].s1, vecs[i].s2, vecs[i].en, vecs[i].dn, vecs[i].er);
         chk({tag, ".rdata"}, 32'(rdata), 32'(vecs[i].rd));
         chk({tag, ".paddr"}, 32'(PADDR), 32'(vecs[i].pa));
         chk({tag, ".pwdata"}, 32'(PWDATA), 32'(vecs[i].pw));
      end

      // Timeout: pointer is 3, so requester 0 wins; rdata is 0x3C going in.
      req = 4'h1; req_write = 4'h0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'hFF;
      tick();
      chk_bus("tmo.setup", 4'h1, 1, 0, 0, 4'h0, 4'h0);
      tick();
      chk_bus("tmo.access", 4'h1, 1, 0, 1, 4'h0, 4'h0);
      for (int c = 1; c < 16; c++) begin
         tick();
         chk($sformatf("tmo.wait%0d.done", c), 32'(done), 32'h0);
         chk($sformatf("tmo.wait%0d.penable", c), 32'(PENABLE), 32'h1);
      end
      tick();
      chk_bus("tmo.done", 4'h0, 0, 0, 0, 4'h1, 4'h1);
      chk("tmo.rdata", 32'(rdata), 32'h00);
      req = 4'h0;
      tick();
      chk_bus("tmo.idle", 4'h0, 0, 0, 0, 4'h0, 4'h0);

      // Round-robin with all four requesting, zero-wait slave.
      PRESET = 1'b1; tick(); PRESET = 1'b0;
      rr_exp  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      rr_addr = '{7'h45, 7'h20, 7'h12, 7'h50, 7'h45};
      req = 4'hF; req_write = 4'hF; PREADY = 1'b1; PRDATA = 8'h00;
      for (int t = 0; t < 5; t++) begin
         string tag;
         tag = $sformatf("rr%0d", t);
         tick();
         chk_bus({tag, ".setup"}, rr_exp[t], rr_addr[t][6], ~rr_addr[t][6], 0, 4'h0, 4'h0);
         chk({tag, ".paddr"}, 32'(PADDR), 32'(rr_addr[t]));
         tick();
         chk({tag, ".access.penable"}, 32'(PENABLE), 32'h1);
         tick();
         chk({tag, ".done"}, 32'(done), 32'(rr_exp[t]));
         chk({tag, ".err"}, 32'(err), 32'h0);
      end
      req = 4'h0;
      tick();

      // Reset while ACCESS is stalled on PREADY.
      req = 4'h4; req_write = 4'h0; PREADY = 1'b0;
      tick();
      tick();
      tick();
      chk("rst.pre.penable", 32'(PENABLE), 32'h1);
      PRESET = 1'b1;
      tick();
      chk_bus("rst.asserted", 4'h0, 0, 0, 0, 4'h0, 4'h0);
      chk("rst.pwrite", 32'(PWRITE), 32'h0);
      chk("rst.paddr", 32'(PADDR), 32'h0);
      chk("rst.pwdata", 32'(PWDATA), 32'h0);
      chk("rst.rdata", 32'(rdata), 32'h0);
      PRESET = 1'b0; req = 4'h0; PREADY = 1'b1;
      tick();
      chk_bus("rst.released", 4'h0, 0, 0, 0, 4'h0, 4'h0);
      req = 4'hF;
      tick();
      chk("rst.first_grant", 32'(grant), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin APB requester arbiter and transfer sequencer. It shares one APB bus among four local requesters, where each requester wants single read or write transfers. It drives the APB SETUP/ACCESS handshake itself, decodes between the two slave selects on PADDR[6], and returns read data, completion and error per requester. It guards every ACCESS phase with a PREADY timeout, so a hung slave cannot stall the bus.

## Interface
Parameters:
- NREQ, 4, number of requesters (fixed at 4; pointer logic is 2 bits)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before forced termination (2..255)

Ports:
- PCLK  input  1  single clock; all logic on rising edge
- PRESET  input  1  reset, synchronous, active-high
- req  input  4  per-requester transfer request, held until matching done
- req_write  input  4  per-requester direction, 1 = write
- req_addr  input  4x7 (28, requester i at [7i+6:7i])  transfer address
- req_wdata  input  4x8 (32, requester i at [8i+7:8i])  write data
- done  output  4  one-cycle completion pulse to the granted requester
- err  output  4  valid with done; 1 = PSLVERR or timeout
- rdata  output  8  read data; valid in the done cycle (shared)
- grant  output  4  one-hot owner of the current transfer; 0 when idle
- PSELECT1  output  1  select, slave 1 (PADDR[6]=1)
- PSELECT2  output  1  select, slave 2 (PADDR[6]=0)
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  7  APB address
- PWDATA  output  8  APB write data
- PRDATA  input  8  slave read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error, sampled with PREADY

## Operation
- All outputs are registered. Reset values:
  - done, err, grant, PSELECT1/2, PENABLE, PWRITE: 0
  - PADDR, PWDATA, rdata: 0
  - State IDLE, rr pointer = 3, timeout counter = 0.
- FSM:
  - **IDLE**: if any req bit is set, pick the winner. Search starts at pointer+1 and wraps modulo 4. Register grant, PADDR, PWRITE and PWDATA from the winner. Drive the select from the winner's address bit 6. Update pointer = winner. Next state SETUP. No request: stay in IDLE with all selects 0.
  - **SETUP**: exactly one cycle with select=1 and PENABLE=0. Next state ACCESS; set PENABLE=1 and clear the counter.
  - **ACCESS**:
    - PREADY=1: capture PRDATA into rdata (reads only; rdata holds on writes). Pulse done[winner] and set err[winner]=PSLVERR. Drop the select, PENABLE and grant. Return to IDLE.
    - PREADY=0: increment the counter. If the counter reaches TIMEOUT-1, complete the same way with err=1 and rdata=0x00. PRDATA is ignored on timeout.
- A requester whose transfer just completed has its req bit ignored in the done cycle (IDLE re-arbitration sees req masked by done). This prevents a double-issue before the requester drops req.
- req deasserted mid-transfer: the transfer still completes on the bus; done still pulses.
- Exactly one select is active in SETUP/ACCESS, and both are 0 in IDLE. PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle.
- Arbitration uses the current-cycle req vector only; no request queuing.

## Timing
- Request sampled in IDLE at edge N:
  - SETUP visible in cycle N+1
  - ACCESS in cycle N+2
  - PREADY=1 in cycle N+2 gives done in cycle N+3
- Zero-wait transfer: 3 cycles from req to done.
- Back-to-back: the done cycle is IDLE and arbitrates, so the next SETUP starts in the cycle after done. Bus occupancy is 3 cycles per zero-wait transfer.
- Timeout: done+err occurs TIMEOUT cycles after ACCESS entry.
- PRESET asserted in any state: on the next edge, the outputs listed above go to their reset values. Any in-flight transfer is abandoned with no done pulse.
- PSLVERR with PREADY=0 is ignored.

## Test plan
- **Single write, zero-wait.** Reset, then req=0001, addr0=0x45, wdata0=0xA5, write, PREADY=1.
  - SETUP cycle: PSELECT1=1, PENABLE=0, PADDR=0x45, PWDATA=0xA5.
  - ACCESS cycle: PENABLE=1.
  - Next cycle: done=0001, err=0000.
- **Read with wait states.** req=0100, addr2=0x12, read; PREADY low for 3 ACCESS cycles, then high with PRDATA=0x3C.
  - PSELECT2=1 throughout.
  - done=0100 and rdata=0x3C, 6 cycles after the request.
- **Round-robin fairness.** req=1111 held.
  - Grant sequence after reset: 0001, 0010, 0100, 1000, 0001.
  - Each done is followed by SETUP of the next requester 1 cycle later.
- **Timeout.** PREADY stuck 0, TIMEOUT=16.
  - done and err for the winner 16 cycles after ACCESS entry; rdata=0x00.
  - Bus idle the next cycle.
- **Slave error.** PREADY=1 with PSLVERR=1 on a write from requester 3: done=1000, err=1000.
- **Reset mid-ACCESS.** Assert PRESET while PREADY is held low.
  - Next edge: all outputs 0, state IDLE, no done pulse.
  - After release, req=0001 is granted first (pointer reset to 3).
